// File: rtl/riscv_core_muldiv.sv
// riscv_core_muldiv: sequential RV M-extension unit (MUL/MULH*/DIV*/REM* plus RV64 word forms).
// Latency: done pulses N+2 edges after accept (N=XLEN, 32 for word ops). Divide-by-zero,
//   signed overflow and (with RISCV_MULDIV_FAST_MUL_EN defined) all multiplies pulse 1 edge after accept.
// Backpressure: o_md_ready only in IDLE; o_md_busy in CALC/DONE stalls the pipe; i_md_flush kills the op.
module riscv_core_muldiv #(
  parameter int XLEN = 64
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_md_valid,
  output logic            o_md_ready,
  input  logic [2:0]      i_md_op,
  input  logic            i_md_isword,
  input  logic [XLEN-1:0] i_md_srcA,
  input  logic [XLEN-1:0] i_md_srcB,
  input  logic            i_md_flush,
  output logic            o_md_busy,
  output logic            o_md_done,
  output logic [XLEN-1:0] o_md_result
);
  localparam int CW = $clog2(XLEN + 1);
  localparam int PW = 2 * XLEN;
  // The counter runs one past the last iteration: that extra CALC cycle applies sign fix-up.
  localparam logic [CW-1:0] N_FULL = CW'(XLEN);
  localparam logic [CW-1:0] N_WORD = CW'(32);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]   counter;
  logic [2:0]      op_q;
  logic            word_q, neg_q, rneg_q;
  logic [XLEN-1:0] a_q;    // multiplier (shifts right) / dividend becoming quotient (shifts left)
  logic [PW-1:0]   b_q;    // multiplicand (shifts left) / divisor in the low half
  logic [PW-1:0]   p_q;    // product accumulator / partial remainder in the low half
  logic [XLEN-1:0] res_q;  // final result waiting for the DONE cycle

  logic            is_div, is_mulh, sgn_a, sgn_b, word_in, neg_a, neg_b;
  logic [XLEN-1:0] ext_a, ext_b, mag_a, mag_b, dvd_val, ovf_min, special_res;
  logic            div_zero, div_ovf, special, accept, zero_iter;
  logic [CW-1:0]   n_last;
  logic [XLEN:0]   rem_sh, rem_diff;
  logic [XLEN-1:0] quo, rem, div_res, final_res;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
    sext32 = XLEN'($signed(x[31:0]));
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] x);
    zext32 = XLEN'(x[31:0]);
  endfunction

  // Apply the product sign, then pick low half (MUL/MULW) or high half (MULH*).
  function automatic logic [XLEN-1:0] fmt_mul(input logic [PW-1:0] mag, input logic neg,
                                              input logic [2:0] op, input logic word);
    logic [PW-1:0] prod;
    prod = neg ? -mag : mag;
    if (op[1:0] == 2'b00) fmt_mul = word ? sext32(prod[XLEN-1:0]) : prod[XLEN-1:0];
    else                  fmt_mul = prod[PW-1:XLEN];
  endfunction

  assign o_md_ready = (state == IDLE);
  assign o_md_busy  = (state != IDLE);
  assign accept     = i_md_valid && o_md_ready && !i_md_flush;
  assign n_last     = word_q ? N_WORD : N_FULL;

  // Decode the incoming request: signedness, operand extension, magnitudes, zero-iteration cases.
  always_comb begin
    is_div  = i_md_op[2];
    is_mulh = !i_md_op[2] && (i_md_op[1:0] != 2'b00);
    sgn_a   = is_div ? !i_md_op[0] : (i_md_op[1:0] == 2'b01 || i_md_op[1:0] == 2'b10);
    sgn_b   = is_div ? !i_md_op[0] : (i_md_op[1:0] == 2'b01);
    word_in = (XLEN == 64) && i_md_isword && !is_mulh;
    ext_a   = word_in ? (sgn_a ? sext32(i_md_srcA) : zext32(i_md_srcA)) : i_md_srcA;
    ext_b   = word_in ? (sgn_b ? sext32(i_md_srcB) : zext32(i_md_srcB)) : i_md_srcB;
    neg_a   = sgn_a && ext_a[XLEN-1];
    neg_b   = sgn_b && ext_b[XLEN-1];
    mag_a   = neg_a ? -ext_a : ext_a;
    mag_b   = neg_b ? -ext_b : ext_b;
    dvd_val = word_in ? sext32(i_md_srcA) : i_md_srcA;
    ovf_min = word_in ? ~XLEN'(32'h7FFF_FFFF) : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (ext_b == '0);
    div_ovf  = !i_md_op[0] && (ext_a == ovf_min) && (&ext_b);
    special  = is_div && (div_zero || div_ovf);
    if (div_zero) special_res = i_md_op[1] ? dvd_val : '1;
    else          special_res = i_md_op[1] ? '0 : dvd_val;
  end

`ifdef RISCV_MULDIV_FAST_MUL_EN
  logic [PW-1:0]   fast_prod;
  logic [XLEN-1:0] fast_res;
  // Single-cycle magnitude product, signed and formatted in the accept cycle.
  always_comb begin
    fast_prod = PW'(mag_a) * PW'(mag_b);
    fast_res  = fmt_mul(fast_prod, neg_a ^ neg_b, i_md_op, word_in);
  end
  assign zero_iter = special || !is_div;
`else
  assign zero_iter = special;
`endif

  // One restoring-divide step: shift the next dividend bit into the remainder and trial-subtract.
  always_comb begin
    rem_sh   = {p_q[XLEN-1:0], a_q[XLEN-1]};
    rem_diff = rem_sh - {1'b0, b_q[XLEN-1:0]};
  end

  // Sign fix-up and result selection once all iterations are finished.
  always_comb begin
    quo     = neg_q ? -a_q : a_q;
    rem     = rneg_q ? -p_q[XLEN-1:0] : p_q[XLEN-1:0];
    div_res = op_q[1] ? rem : quo;
    if (word_q) div_res = sext32(div_res);
    final_res = op_q[2] ? div_res : fmt_mul(p_q, neg_q, op_q, word_q);
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = zero_iter ? DONE : CALC;
      CALC:    if (counter == n_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (i_md_flush) state_nxt = IDLE;
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Operand capture, iteration datapath and result/done registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      counter     <= '0;
      op_q        <= '0;
      word_q      <= 1'b0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      p_q         <= '0;
      res_q       <= '0;
      o_md_done   <= 1'b0;
      o_md_result <= '0;
    end else begin
      o_md_done <= 1'b0;
      if (i_md_flush) begin
        counter <= '0;
      end else begin
        case (state)
          IDLE: if (accept) begin
            counter <= '0;
            op_q    <= i_md_op;
            word_q  <= word_in;
            neg_q   <= neg_a ^ neg_b;
            rneg_q  <= neg_a;
            p_q     <= '0;
            if (is_div) begin
              // Word divides start with the 32-bit dividend in the top bits so 32 steps consume it.
              a_q <= word_in ? (mag_a << (XLEN - 32)) : mag_a;
              b_q <= PW'(mag_b);
            end else begin
              a_q <= mag_b;
              b_q <= PW'(mag_a);
            end
`ifdef RISCV_MULDIV_FAST_MUL_EN
            res_q <= is_div ? special_res : fast_res;
`else
            res_q <= special_res;
`endif
          end
          CALC: begin
            counter <= counter + CW'(1);
            if (counter == n_last) begin
              res_q <= final_res;
            end else if (op_q[2]) begin
              if (!rem_diff[XLEN]) begin
                p_q <= PW'(rem_diff[XLEN-1:0]);
                a_q <= {a_q[XLEN-2:0], 1'b1};
              end else begin
                p_q <= PW'(rem_sh[XLEN-1:0]);
                a_q <= {a_q[XLEN-2:0], 1'b0};
              end
            end else begin
              if (a_q[0]) p_q <= p_q + b_q;
              b_q <= b_q << 1;
              a_q <= a_q >> 1;
            end
          end
          DONE: begin
            counter     <= '0;
            o_md_result <= res_q;
            o_md_done   <= 1'b1;
          end
          default: counter <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_riscv_core_muldiv.sv
// tb_riscv_core_muldiv: scoreboard bench for riscv_core_muldiv at XLEN=64.
// Latency: expected done latency is carried with each queued result.
// Backpressure: one request in flight; the driver waits for done before the next request.
module tb_riscv_core_muldiv;
  localparam int XLEN = 64;
  localparam int LAT_DIV  = 66;
  localparam int LAT_WORD = 34;
  localparam int LAT_SPEC = 1;
`ifdef RISCV_MULDIV_FAST_MUL_EN
  localparam int LAT_MUL  = 1;
  localparam int LAT_MULW = 1;
`else
  localparam int LAT_MUL  = 66;
  localparam int LAT_MULW = 34;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            valid, ready, isword, flush, busy, done;
  logic [2:0]      md_op;
  logic [XLEN-1:0] src_a, src_b, result;

  riscv_core_muldiv #(.XLEN(XLEN)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_md_valid  (valid),
    .o_md_ready  (ready),
    .i_md_op     (md_op),
    .i_md_isword (isword),
    .i_md_srcA   (src_a),
    .i_md_srcB   (src_b),
    .i_md_flush  (flush),
    .o_md_busy   (busy),
    .o_md_done   (done),
    .o_md_result (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          acc_cyc;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  logic [63:0] last_res = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // Monitor: every done pulse pops the oldest expectation and checks value and latency.
  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk({e.tag, "_res"}, result, e.res);
        chk({e.tag, "_lat"}, 64'(cyc - e.acc_cyc), 64'(e.lat));
      end
    end
  end

  task automatic push_exp(input string tag, input logic [63:0] res, input int lat);
    exp_t e;
    e.res = res; e.lat = lat; e.acc_cyc = cyc; e.tag = tag;
    exp_q.push_back(e);
    last_res = res;
  endtask

  task automatic wait_done(input string tag, input int start);
    for (int i = 0; i < 200 && done_cnt == start; i++) @(negedge clk);
    if (done_cnt == start) chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_res, input int lat);
    int start;
    @(negedge clk);
    chk({tag, "_rdy"}, 64'(ready), 64'd1);
    valid = 1'b1; md_op = op; isword = w; src_a = a; src_b = b;
    @(posedge clk); #1;
    push_exp(tag, exp_res, lat);
    start = done_cnt;
    // Scramble inputs after the accept edge: the unit must work from latched copies.
    valid = 1'b0; md_op = 3'($urandom); isword = 1'($urandom);
    src_a = {$urandom, $urandom}; src_b = {$urandom, $urandom};
    wait_done(tag, start);
  endtask

  initial begin
    logic [63:0] ra, rb;
    int          saved;
    rst = 1'b1; valid = 1'b0; flush = 1'b0; isword = 1'b0; md_op = '0;
    src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready",  64'(ready), 64'd1);
    chk("reset_busy",   64'(busy),  64'd0);
    chk("reset_done",   64'(done),  64'd0);
    chk("reset_result", result,     64'd0);
    rst = 1'b0;

    run_op("div_m7_2",   3'b100, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, LAT_DIV);
    run_op("rem_m7_2",   3'b110, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, LAT_DIV);
    run_op("divu_by0",   3'b101, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, LAT_SPEC);
    run_op("remu_by0",   3'b111, 1'b0, 64'd5, 64'd0, 64'd5, LAT_SPEC);
    run_op("div_ovf",    3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, LAT_SPEC);
    run_op("rem_ovf",    3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'd0, LAT_SPEC);
    run_op("mulhu_ones", 3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFE, LAT_MUL);
    run_op("mul_ones",   3'b000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'd1, LAT_MUL);
    run_op("mulhsu_m1",  3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFF, LAT_MUL);
    run_op("mulh_pos",   3'b001, 1'b0, 64'h4000_0000_0000_0000, 64'd4, 64'd1, LAT_MUL);
    run_op("mulh_isword", 3'b001, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'd0, LAT_MUL);
    run_op("mul_neg",    3'b000, 1'b0, -64'sd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1, LAT_MUL);
    run_op("mulw",       3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, LAT_MULW);
    run_op("divw_ovf",   3'b100, 1'b1, 64'h1_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, LAT_SPEC);
    run_op("divuw",      3'b101, 1'b1, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, LAT_WORD);
    run_op("remw",       3'b110, 1'b1, 64'hABCD_0000_FFFF_FFF9, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFF, LAT_WORD);
    run_op("remuw",      3'b111, 1'b1, 64'h5_8000_0007, 64'h10, 64'd7, LAT_WORD);
    run_op("divu_100_7", 3'b101, 1'b0, 64'd100, 64'd7, 64'd14, LAT_DIV);

    // Random unsigned divides/multiplies against native 64-bit arithmetic.
    for (int i = 0; i < 3; i++) begin
      ra = {$urandom, $urandom};
      rb = {16'd0, 16'($urandom), $urandom} | 64'd1;
      run_op("rnd_divu", 3'b101, 1'b0, ra, rb, ra / rb, LAT_DIV);
      run_op("rnd_remu", 3'b111, 1'b0, ra, rb, ra % rb, LAT_DIV);
      run_op("rnd_mul",  3'b000, 1'b0, ra, rb, ra * rb, LAT_MUL);
    end

    // Flush on the 10th CALC cycle of a DIV, then an accept one cycle later.
    @(negedge clk);
    valid = 1'b1; md_op = 3'b100; isword = 1'b0; src_a = 64'd1000; src_b = 64'd7;
    @(posedge clk); #1;
    valid = 1'b0;
    saved = done_cnt;
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush_ready",  64'(ready), 64'd1);
    chk("flush_busy",   64'(busy),  64'd0);
    chk("flush_result", result,     last_res);
    run_op("after_flush", 3'b110, 1'b0, 64'd1000, 64'd7, 64'd6, LAT_DIV);
    chk("flush_done_count", 64'(done_cnt), 64'(saved + 1));

    // Flush beats a same-cycle valid.
    @(negedge clk);
    valid = 1'b1; flush = 1'b1; md_op = 3'b101; src_a = 64'd9; src_b = 64'd3;
    @(posedge clk); #1;
    valid = 1'b0; flush = 1'b0;
    chk("flush_vs_valid_busy", 64'(busy), 64'd0);

    // Async reset mid-DIV; valid held through reset is only taken after release.
    @(negedge clk);
    valid = 1'b1; md_op = 3'b100; isword = 1'b0; src_a = 64'd12345; src_b = 64'd3;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (20) @(posedge clk);
    #3; rst = 1'b1; #1;
    chk("arst_ready",  64'(ready), 64'd1);
    chk("arst_busy",   64'(busy),  64'd0);
    chk("arst_done",   64'(done),  64'd0);
    chk("arst_result", result,     64'd0);
    exp_q.delete();
    valid = 1'b1; md_op = 3'b101; src_a = 64'd100; src_b = 64'd7;
    repeat (3) @(posedge clk);
    #1;
    chk("arst_hold_busy", 64'(busy), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    push_exp("post_reset", 64'd14, LAT_DIV);
    saved = done_cnt;
    valid = 1'b0;
    chk("post_reset_busy", 64'(busy), 64'd1);
    wait_done("post_reset", saved);

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
